// File: rtl/npc_mem_pkg.sv
// Shared memop codes, trap instruction and response-tracking stage type for npc_mem_arb.
package npc_mem_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    // Channel id field is sized for the largest supported channel count.
    localparam int unsigned ID_MAX_W = 8;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
        logic                wen;
    } trk_stage_t;

    // Channel id width, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/npc_rr_arb.sv
// Round-robin grant: one-hot grant searching upward from ptr, plus next pointer.
module npc_rr_arb
    import npc_mem_pkg::*;
#(
    parameter int unsigned NCH = 2,
    parameter int unsigned IDW = id_width(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IDW-1:0] ptr,
    input  logic           block,
    output logic [NCH-1:0] gnt_c,
    output logic [IDW-1:0] gnt_id_c,
    output logic           gnt_any_c,
    output logic [IDW-1:0] ptr_next_c
);

    logic           hi_hit;
    logic           lo_hit;
    logic [IDW-1:0] hi_sel;
    logic [IDW-1:0] lo_sel;

    // Lowest requester at/above ptr wins, else lowest requester overall.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_sel = '0;
        lo_sel = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_hit = 1'b1;
                lo_sel = IDW'(i);
                if (IDW'(i) >= ptr) begin
                    hi_hit = 1'b1;
                    hi_sel = IDW'(i);
                end
            end
        end
    end

    // Grant vector and pointer advance; pointer holds when nothing is granted.
    always_comb begin
        gnt_any_c  = lo_hit & ~block;
        gnt_id_c   = hi_hit ? hi_sel : lo_sel;
        gnt_c      = '0;
        ptr_next_c = ptr;
        if (gnt_any_c) begin
            gnt_c      = NCH'(1) << gnt_id_c;
            ptr_next_c = (gnt_id_c == IDW'(NCH - 1)) ? '0 : gnt_id_c + IDW'(1);
        end
    end

endmodule

// File: rtl/npc_mem_arb.sv
// N-channel memory arbiter: round-robin valid/ready grants onto one memory port,
// fixed-latency response pipe. Optional ebreak trap monitor: define NPC_ARB_TRAP_EN.
module npc_mem_arb
    import npc_mem_pkg::*;
#(
    parameter int unsigned NCH = 2,
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req_valid,
    output logic [NCH-1:0]    req_ready,
    input  logic [NCH*AW-1:0] req_addr,
    input  logic [NCH-1:0]    req_wen,
    input  logic [NCH*3-1:0]  req_wop,
    input  logic [NCH*DW-1:0] req_wdata,
    output logic [NCH-1:0]    resp_valid,
    output logic [DW-1:0]     resp_data,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [2:0]        mem_wop,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic              trap,
    output logic [31:0]       trap_cycle
);

    localparam int unsigned IDW = id_width(NCH);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] ptr_next;
    logic [IDW-1:0] gnt_id;
    logic           gnt_any;
    logic           halted;
    trk_stage_t     pipe [LAT];
    logic [DW-1:0]  rdata_q;

    npc_rr_arb #(
        .NCH (NCH),
        .IDW (IDW)
    ) u_rr_arb (
        .req        (req_valid),
        .ptr        (rr_ptr),
        .block      (halted),
        .gnt_c      (req_ready),
        .gnt_id_c   (gnt_id),
        .gnt_any_c  (gnt_any),
        .ptr_next_c (ptr_next)
    );

    // Granted channel's payload onto the memory port; all zero when idle.
    always_comb begin
        mem_en    = gnt_any;
        mem_wen   = 1'b0;
        mem_wop   = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_any) begin
            mem_wen   = req_wen[gnt_id];
            mem_wop   = req_wop[32'(gnt_id) * 3 +: 3];
            mem_addr  = req_addr[32'(gnt_id) * AW +: AW];
            mem_wdata = req_wdata[32'(gnt_id) * DW +: DW];
        end
    end

    // Pointer, non-stalling tracking pipe and read-data capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr  <= '0;
            rdata_q <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            rr_ptr  <= ptr_next;
            rdata_q <= mem_rdata;
            pipe[0] <= trk_stage_t'{valid: gnt_any,
                                    id:    ID_MAX_W'(gnt_id),
                                    wen:   gnt_any & req_wen[gnt_id]};
            for (int unsigned i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Pipe exit: one-cycle pulse on the owning channel; writes return zero data.
    always_comb begin
        resp_valid = '0;
        resp_data  = '0;
        if (pipe[LAT-1].valid) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (pipe[LAT-1].id == ID_MAX_W'(i)) begin
                    resp_valid[i] = 1'b1;
                end
            end
            if (!pipe[LAT-1].wen) begin
                resp_data = rdata_q;
            end
        end
    end

`ifdef NPC_ARB_TRAP_EN
    logic [31:0] cyc_cnt;
    logic        trap_q;
    logic [31:0] trap_cycle_q;
    logic        trap_hit_c;

    assign trap_hit_c = pipe[LAT-1].valid && !pipe[LAT-1].wen &&
                        (pipe[LAT-1].id == '0) && (resp_data == DW'(EBREAK_INST));

    // Free-running cycle counter and sticky trap capture on a fetched ebreak.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt      <= '0;
            trap_q       <= 1'b0;
            trap_cycle_q <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (trap_hit_c && !trap_q) begin
                trap_q       <= 1'b1;
                trap_cycle_q <= cyc_cnt;
            end
        end
    end

    assign halted     = trap_q;
    assign trap       = trap_q;
    assign trap_cycle = trap_cycle_q;
`else
    assign halted     = 1'b0;
    assign trap       = 1'b0;
    assign trap_cycle = '0;
`endif

endmodule

// File: tb/tb_npc_mem_arb.sv
// Scoreboard bench for npc_mem_arb: two instances (LAT=1 and LAT=3) share stimulus;
// each has its own memory model, reference model and response monitor.
module tb_npc_mem_arb;
    import npc_mem_pkg::*;

    localparam int unsigned NCH  = 3;
    localparam int          NCHI = 3;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam logic [31:0] TRAP_ADDR = 32'h8000_0F00;

    typedef struct {
        int          ch;
        logic [31:0] data;
        logic        rd0;
        int          due;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NCH-1:0]    req_valid = '0;
    logic [NCH-1:0]    req_wen   = '0;
    logic [NCH*AW-1:0] req_addr  = '0;
    logic [NCH*3-1:0]  req_wop   = '0;
    logic [NCH*DW-1:0] req_wdata = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    // Cycles since reset release; matches the counter the trap monitor records.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Memory contents as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h1234_5678;
        if (a == TRAP_ADDR)     return EBREAK_INST;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input int inst, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL [inst%0d] %s at cycle %0d: got %h, expected %h", inst, name, cyc, act, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int unsigned LAT = (k == 0) ? 1 : 3;

        logic [NCH-1:0] req_ready;
        logic [NCH-1:0] resp_valid;
        logic [DW-1:0]  resp_data;
        logic           mem_en;
        logic           mem_wen;
        logic [2:0]     mem_wop;
        logic [AW-1:0]  mem_addr;
        logic [DW-1:0]  mem_wdata;
        logic [DW-1:0]  mem_rdata;
        logic           trap;
        logic [31:0]    trap_cycle;

        npc_mem_arb #(.NCH(NCH), .AW(AW), .DW(DW), .LAT(LAT)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid),
            .req_ready  (req_ready),
            .req_addr   (req_addr),
            .req_wen    (req_wen),
            .req_wop    (req_wop),
            .req_wdata  (req_wdata),
            .resp_valid (resp_valid),
            .resp_data  (resp_data),
            .mem_en     (mem_en),
            .mem_wen    (mem_wen),
            .mem_wop    (mem_wop),
            .mem_addr   (mem_addr),
            .mem_wdata  (mem_wdata),
            .mem_rdata  (mem_rdata),
            .trap       (trap),
            .trap_cycle (trap_cycle)
        );

        // Memory model: read data presented LAT-1 cycles after the access.
        logic [AW-1:0]  rd_addr [LAT];
        logic [LAT-1:0] rd_v;

        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                rd_v <= '0;
            end else begin
                rd_v       <= LAT'({rd_v, (mem_en & ~mem_wen)});
                rd_addr[0] <= mem_addr;
                for (int i = 1; i < int'(LAT); i++) rd_addr[i] <= rd_addr[i-1];
            end
        end

        if (LAT == 1) begin : g_mem0
            assign mem_rdata = (mem_en && !mem_wen) ? mem_word(mem_addr) : 32'hBAD0_BAD0;
        end else begin : g_memn
            assign mem_rdata = rd_v[LAT-2] ? mem_word(rd_addr[LAT-2]) : 32'hBAD0_BAD0;
        end

        // Reference model and monitor, evaluated mid-cycle.
        exp_t        sbq[$];
        int          m_ptr = 0;
        logic        m_trap = 1'b0;
        logic [31:0] m_trap_cycle = '0;

        always @(negedge clk) begin : p_mon
            exp_t        e;
            int          g;
            logic        hit;
            logic [31:0] a;
            hit = 1'b0;
            if (!rst) begin
                sbq.delete();
                m_ptr        = 0;
                m_trap       = 1'b0;
                m_trap_cycle = '0;
                chk(k, "rst_req_ready",  64'(req_ready),  64'(0));
                chk(k, "rst_resp_valid", 64'(resp_valid), 64'(0));
                chk(k, "rst_resp_data",  64'(resp_data),  64'(0));
                chk(k, "rst_mem_en",     64'(mem_en),     64'(0));
                chk(k, "rst_mem_wen",    64'(mem_wen),    64'(0));
                chk(k, "rst_mem_wop",    64'(mem_wop),    64'(0));
                chk(k, "rst_mem_addr",   64'(mem_addr),   64'(0));
                chk(k, "rst_mem_wdata",  64'(mem_wdata),  64'(0));
                chk(k, "rst_trap",       64'(trap),       64'(0));
                chk(k, "rst_trap_cycle", 64'(trap_cycle), 64'(0));
            end else begin
                if (sbq.size() > 0 && sbq[0].due == cyc) begin
                    e = sbq.pop_front();
                    chk(k, "resp_valid", 64'(resp_valid), 64'(1) << e.ch);
                    chk(k, "resp_data",  64'(resp_data),  64'(e.data));
`ifdef NPC_ARB_TRAP_EN
                    if (e.rd0 && e.data == EBREAK_INST && !m_trap) hit = 1'b1;
`endif
                end else begin
                    chk(k, "resp_idle", 64'(resp_valid), 64'(0));
                end
                chk(k, "trap",       64'(trap),       64'(m_trap));
                chk(k, "trap_cycle", 64'(trap_cycle), 64'(m_trap_cycle));

                g = -1;
                if (!m_trap) begin
                    for (int j = 0; j < NCHI; j++) begin
                        if (g < 0 && req_valid[(m_ptr + j) % NCHI]) g = (m_ptr + j) % NCHI;
                    end
                end
                if (g >= 0) begin
                    a = req_addr[g*AW +: AW];
                    chk(k, "req_ready", 64'(req_ready), 64'(1) << g);
                    chk(k, "mem_en",    64'(mem_en),    64'(1));
                    chk(k, "mem_addr",  64'(mem_addr),  64'(a));
                    chk(k, "mem_wen",   64'(mem_wen),   64'(req_wen[g]));
                    chk(k, "mem_wop",   64'(mem_wop),   64'(req_wop[g*3 +: 3]));
                    chk(k, "mem_wdata", 64'(mem_wdata), 64'(req_wdata[g*DW +: DW]));
                    e.ch   = g;
                    e.data = req_wen[g] ? 32'h0 : mem_word(a);
                    e.rd0  = (g == 0) && !req_wen[g];
                    e.due  = cyc + int'(LAT);
                    sbq.push_back(e);
                    m_ptr = (g + 1) % NCHI;
                end else begin
                    chk(k, "ready_idle",  64'(req_ready), 64'(0));
                    chk(k, "mem_en_idle", 64'(mem_en),    64'(0));
                    chk(k, "mem_wen_idle", 64'(mem_wen),  64'(0));
                    chk(k, "mem_addr_idle", 64'(mem_addr), 64'(0));
                end
                if (hit) begin
                    m_trap       = 1'b1;
                    m_trap_cycle = 32'(cyc);
                end
            end
        end
    end

    // Raise a request on channel c; it stays up until granted.
    task automatic arm(input int c, input logic [31:0] a, input logic w,
                       input logic [2:0] op, input logic [31:0] d);
        req_addr[c*AW +: AW]  = a;
        req_wen[c]            = w;
        req_wop[c*3 +: 3]     = op;
        req_wdata[c*DW +: DW] = d;
        req_valid[c]          = 1'b1;
    endtask

    // One clock: drop requests that were granted at this edge.
    task automatic step();
        logic [NCH-1:0] fired;
        @(negedge clk);
        fired = req_valid & g_dut[0].req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~fired;
    endtask

    task automatic do_reset(input int cycles);
        rst       = 1'b0;
        req_valid = '0;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = {2'b10, 28'($urandom), 2'b00};
        if (a == TRAP_ADDR) a = a ^ 32'h10;
        return a;
    endfunction

    function automatic logic [2:0] rand_wop();
        case ($urandom_range(0, 4))
            0:       return MEMOP_B;
            1:       return MEMOP_H;
            2:       return MEMOP_W;
            3:       return MEMOP_BU;
            default: return MEMOP_HU;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Single fetch read.
        arm(0, 32'h8000_0000, 1'b0, MEMOP_W, 32'h0);
        repeat (4) step();

        // Two channels continuously requesting.
        for (int n = 0; n < 4; n++) begin
            if (!req_valid[0]) arm(0, rand_addr(), 1'b0, MEMOP_W, 32'h0);
            if (!req_valid[1]) arm(1, rand_addr(), 1'b0, MEMOP_W, 32'h0);
            step();
        end
        req_valid = '0;
        repeat (4) step();

        // Back-to-back reads from channel 1.
        for (int n = 0; n < 3; n++) begin
            arm(1, rand_addr(), 1'b0, MEMOP_W, 32'h0);
            step();
        end
        repeat (5) step();

        // Word write on channel 1.
        arm(1, rand_addr(), 1'b1, MEMOP_W, 32'hDEAD_BEEF);
        repeat (5) step();

        // Reset one cycle after a grant: the in-flight response must vanish.
        arm(0, rand_addr(), 1'b0, MEMOP_W, 32'h0);
        step();
        @(posedge clk);
        #1 do_reset(2);
        repeat (6) step();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NCHI; c++) begin
                if (!req_valid[c] && $urandom_range(0, 99) < 55)
                    arm(c, rand_addr(), ($urandom_range(0, 9) < 3), rand_wop(), $urandom());
            end
            step();
        end
        req_valid = '0;
        repeat (6) step();

`ifdef NPC_ARB_TRAP_EN
        // Fetch returns ebreak at cycle 20 on the LAT=1 instance.
        do_reset(2);
        while (cyc < 19) step();
        arm(0, TRAP_ADDR, 1'b0, MEMOP_W, 32'h0);
        arm(1, rand_addr(), 1'b0, MEMOP_W, 32'h0);
        step();
        for (int n = 0; n < 10; n++) begin
            if (!req_valid[0]) arm(0, rand_addr(), 1'b0, MEMOP_W, 32'h0);
            if (!req_valid[1]) arm(1, rand_addr(), 1'b0, MEMOP_W, 32'h0);
            step();
        end
        @(negedge clk);
        chk(0, "trap_set",       64'(g_dut[0].trap),       64'(1));
        chk(0, "trap_cycle_20",  64'(g_dut[0].trap_cycle), 64'(20));
        chk(0, "halted_ready",   64'(g_dut[0].req_ready),  64'(0));
        chk(1, "halted_ready",   64'(g_dut[1].req_ready),  64'(0));
        req_valid = '0;
        repeat (4) step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/npc_mem_arb.md
# npc_mem_arb

Parametrised N-channel memory arbiter between the NPC core's request sources (channel 0 = instruction fetch, channel 1 = load/store, extra channels for future masters) and the single simulation memory port of the top-level harness. It replaces the direct single-port fetch/memory wiring with valid/ready request handshakes, round-robin arbitration and a fixed-latency response pipeline. An optional trap monitor detects `ebreak` on the fetch channel and halts new grants.

## Interface
Parameters:
- `NCH`, 2: number of request channels (≥1); channel 0 is the fetch channel.
- `AW`, 32: address width.
- `DW`, 32: data width.
- `LAT`, 1: memory read latency in cycles (≥1).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NCH  per-channel request valid.
- `req_ready`  out  NCH  per-channel grant; a transfer occurs when valid&ready.
- `req_addr`  in  NCH*AW  packed addresses, channel i at [i*AW +: AW].
- `req_wen`  in  NCH  1 = write, 0 = read.
- `req_wop`  in  NCH*3  packed memop codes (byte/half/word, signed/unsigned).
- `req_wdata`  in  NCH*DW  packed write data.
- `resp_valid`  out  NCH  one-cycle response pulse per channel.
- `resp_data`  out  DW  response data, shared; qualified by `resp_valid`.
- `mem_en`  out  1  memory access issued this cycle.
- `mem_wen`  out  1  write strobe.
- `mem_wop`  out  3  memop of issued access.
- `mem_addr`  out  AW  address of issued access.
- `mem_wdata`  out  DW  write data of issued access.
- `mem_rdata`  in  DW  read data, valid LAT-1 cycles after `mem_en`.
- `trap`  out  1  sticky trap flag (only with trap monitor).
- `trap_cycle`  out  32  cycle counter value at trap (only with trap monitor).

## Operation
- At most one grant per cycle; `req_ready` is one-hot or zero, combinational from `req_valid`, the round-robin pointer and `halted`.
- Round-robin: search starts at `rr_ptr`; after a grant to channel g, `rr_ptr` ← (g+1) mod NCH. No grant: pointer holds.
- Grant drives `mem_en`=1 and the granted channel's addr/wen/wop/wdata onto `mem_*`; otherwise `mem_en`=0, `mem_wen`=0, other `mem_*` = 0.
- Tracking pipe: LAT stages of {valid, channel id, wen}. Stage 0 loads the grant; stages shift every cycle. Pipe never stalls.
- Pipe exit: `resp_valid[id]`=1 for one cycle; `resp_data` = registered `mem_rdata` for reads, 0 for writes.
- Channel ids: width $clog2(NCH), minimum 1.
- Requesters keep `req_valid` and payload stable until granted; the block does not check.

## Timing
- Reset (async assert, sync-free release): `req_ready` follows combinational rule with empty pipe; `resp_valid`=0, `resp_data`=0, `mem_*`=0, `rr_ptr`=0, pipe cleared, `trap`=0, `trap_cycle`=0, cycle counter 0.
- Grant at cycle t → `resp_valid` at cycle t+LAT; throughput one access per cycle.
- Back-to-back grants from different channels produce back-to-back responses in grant order.
- Reset mid-operation: all in-flight responses are dropped, no `resp_valid` after release for pre-reset accesses.
- NCH=1: pointer constant 0, grant = `req_valid[0]` & ~halted.

## Configuration
- `NPC_ARB_TRAP_EN` defined: 32-bit free-running cycle counter (wraps); when a channel-0 read response has `resp_data` = 32'h00100073, `trap`←1 (sticky until reset) and `trap_cycle` ← counter value that cycle; `halted`=`trap` blocks all further grants; in-flight responses still complete. A write response never triggers.
- Undefined: no counter or monitor; `trap` and `trap_cycle` tied to 0; grants never blocked.

## Structure
- Package `npc_mem_pkg`: memop encoding constants (3-bit), `EBREAK_INST` = 32'h00100073, tracking-stage struct typedef {valid, id, wen}.
- One sub-module `npc_rr_arb` (parametrised by NCH): one-hot grant from request vector and pointer, plus pointer update.

## Test plan
- NCH=2, LAT=1: single read ch0 addr 0x80000000, mem_rdata=0x12345678 → `mem_en` at t, `resp_valid`=2'b01 and `resp_data`=0x12345678 at t+1.
- Both channels valid continuously for 4 cycles → grants alternate 01,10,01,10; responses in same order.
- LAT=3, three back-to-back reads from ch1 → three consecutive `resp_valid[1]` pulses starting t+3, data in order.
- Write on ch1 (wop=word, wdata=0xDEADBEEF) → `mem_wen`=1 same cycle, `resp_valid[1]` at t+LAT with `resp_data`=0.
- Reset asserted one cycle after a LAT=3 grant → no `resp_valid` ever for that access; all outputs 0 during reset.
- `NPC_ARB_TRAP_EN`, ch0 fetch returns 0x00100073 at cycle 20 → `trap`=1, `trap_cycle`=20, `req_ready`=0 thereafter despite `req_valid`=2'b11.
